// File: rtl/fft_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package    : fft_pkg                                                     |
// | Purpose    : Shared constants and types for the FFT peak detector:      |
// |              datapath widths, FSM state encoding, peak_error bit index. |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  // Default datapath widths (FFT output width, frame-length width, |X|^2 width)
  localparam int FFT_DATA_W = 25;
  localparam int FFT_PTS_W  = 14;
  localparam int FFT_MAG_W  = 2 * FFT_DATA_W;

  // Frame-tracking state machine
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Bit positions inside peak_error
  localparam int ERR_SINK    = 0;  // some beat carried a nonzero sink_error
  localparam int ERR_RESTART = 1;  // frame was restarted by a sop mid-frame
  localparam int ERR_LEN     = 2;  // frame length did not match N

endpackage

`default_nettype wire

// File: rtl/fft_mag_sq.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module     : fft_mag_sq                                                  |
// | Purpose    : Two-stage registered magnitude-squared, re^2 + im^2.       |
// |              Stage 1 registers the signed inputs, stage 2 registers    |
// |              the unsigned sum. Latency is two clock edges.             |
// | Ports      : clk, reset     clock / synchronous active-high reset      |
// |              re_i, im_i     signed DATA_W inputs                        |
// |              mag_o          unsigned MAG_W result                       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int MAG_W  = FFT_MAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] re_i,
  input  logic [DATA_W-1:0] im_i,
  output logic [MAG_W-1:0]  mag_o
);

  logic [DATA_W-1:0] re_q;
  logic [DATA_W-1:0] im_q;
  logic [MAG_W-1:0]  re_ext;
  logic [MAG_W-1:0]  im_ext;
  logic [MAG_W-1:0]  mag_d;
  logic [MAG_W-1:0]  mag_q;

  // Sign-extend to the full result width before squaring. The low MAG_W bits
  // of a two's-complement product equal the true square because
  // (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2) still fits; the sum of two such
  // squares (at most 2^(2*DATA_W-1)) fits unsigned in MAG_W.
  always_comb begin
    re_ext = {{(MAG_W-DATA_W){re_q[DATA_W-1]}}, re_q};
    im_ext = {{(MAG_W-DATA_W){im_q[DATA_W-1]}}, im_q};
    mag_d  = (re_ext * re_ext) + (im_ext * im_ext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      re_q  <= '0;
      im_q  <= '0;
      mag_q <= '0;
    end else begin
      re_q  <= re_i;
      im_q  <= im_i;
      mag_q <= mag_d;
    end
  end

  assign mag_o = mag_q;

endmodule

`default_nettype wire

// File: rtl/fft_peak_detect.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module     : fft_peak_detect                                             |
// | Purpose    : Consumes the FFT Avalon-ST output, computes re^2+im^2 per  |
// |              bin and reports the largest bin of the lower half-spectrum|
// |              (bins 0..N/2-1) once per frame on a valid/ready port.     |
// | Ports      : clk, reset            clock / sync active-high reset      |
// |              sink_*                FFT Avalon-ST sink (valid/ready,    |
// |                                    sop/eop, error, real, imag)         |
// |              fftpts_in             frame length N, sampled on sop      |
// |              peak_valid/ready      result handshake                    |
// |              peak_bin/mag/error    result: index, |X|^2, error flags   |
// |                                    {len_err, sop_restart, sink_error}  |
// | Config     : FFT_PEAK_DC_SKIP_EN   when defined, bin 0 never competes  |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int PTS_W  = FFT_PTS_W,
  parameter int MAG_W  = FFT_MAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic [1:0]        sink_error,
  input  logic              sink_sop,
  input  logic              sink_eop,
  input  logic [DATA_W-1:0] sink_real,
  input  logic [DATA_W-1:0] sink_imag,
  input  logic [PTS_W-1:0]  fftpts_in,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [PTS_W-1:0]  peak_bin,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [2:0]        peak_error
);

  localparam logic [PTS_W:0] CNT_ONE = {{PTS_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Frame-tracking state
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             drain_q, drain_d;
  logic [PTS_W-1:0] npts_q,  npts_d;
  logic [PTS_W:0]   cnt_q,   cnt_d;     // index of the next expected beat
  logic [2:0]       err_q,   err_d;

  // Beat decode
  logic             accept;
  logic             in_frame;
  logic [PTS_W-1:0] n_cur;
  logic [PTS_W:0]   n_ext;
  logic [PTS_W:0]   half_ext;
  logic [PTS_W:0]   beat_idx;
  logic             len_fault;
  logic             cmp_en;
  logic [2:0]       beat_err;

  // Pipeline sidebands travelling alongside fft_mag_sq
  logic             s1_vld_q, s1_first_q, s1_en_q;
  logic [PTS_W-1:0] s1_bin_q;
  logic             s2_vld_q, s2_first_q, s2_en_q;
  logic [PTS_W-1:0] s2_bin_q;
  logic [MAG_W-1:0] mag;

  // Running maximum
  logic [MAG_W-1:0] max_mag_q, max_mag_d;
  logic [PTS_W-1:0] max_bin_q, max_bin_d;

  // ---------------------------------------------------------------------------
  // Beat decode. Readiness is recomputed from state here rather than taken
  // from sink_ready so the decode and FSM blocks do not feed each other.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept   = sink_valid & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
    // In IDLE only a sop beat opens a frame; everything else is dropped.
    in_frame = accept & (sink_sop | (state_q == ST_ACCUM));
    // N is taken live on the sop beat and from the latch afterwards.
    n_cur    = sink_sop ? fftpts_in : npts_q;
    n_ext    = {1'b0, n_cur};
    half_ext = n_ext >> 1;
    beat_idx = sink_sop ? '0 : cnt_q;
    // Overrun past N-1, or eop with a received count different from N.
    len_fault = (beat_idx >= n_ext) |
                (sink_eop & ((beat_idx + CNT_ONE) != n_ext));
`ifdef FFT_PEAK_DC_SKIP_EN
    cmp_en   = (beat_idx < half_ext) && (beat_idx != '0);
`else
    cmp_en   = (beat_idx < half_ext);
`endif
    beat_err           = '0;
    beat_err[ERR_LEN]  = len_fault;
    beat_err[ERR_SINK] = |sink_error;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    npts_d     = npts_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    sink_ready = 1'b0;
    peak_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sink_ready = 1'b1;
        if (in_frame) begin
          npts_d  = fftpts_in;
          cnt_d   = CNT_ONE;
          err_d   = beat_err;
          state_d = sink_eop ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        sink_ready = 1'b1;
        if (in_frame) begin
          if (sink_sop) begin
            // Restart: the partial frame's flags are discarded with it.
            npts_d             = fftpts_in;
            cnt_d              = CNT_ONE;
            err_d              = beat_err;
            err_d[ERR_RESTART] = 1'b1;
          end else begin
            // Saturate so a runaway frame cannot wrap back into range.
            cnt_d = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
            err_d = err_q | beat_err;
          end
          if (sink_eop) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Two cycles: the last beat is then through mag_sq and the compare.
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        peak_valid = 1'b1;
        if (peak_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      drain_q <= 1'b0;
      npts_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      npts_q  <= npts_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline: stage 1 (input regs) and stage 2 (square-sum) live in
  // fft_mag_sq; the bin index and control tags follow in lockstep.
  // ---------------------------------------------------------------------------
  fft_mag_sq #(
    .DATA_W (DATA_W),
    .MAG_W  (MAG_W)
  ) u_mag_sq (
    .clk   (clk),
    .reset (reset),
    .re_i  (sink_real),
    .im_i  (sink_imag),
    .mag_o (mag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_bin_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_en_q    <= 1'b0;
      s2_bin_q   <= '0;
    end else begin
      s1_vld_q   <= in_frame;
      s1_first_q <= sink_sop;
      s1_en_q    <= cmp_en;
      s1_bin_q   <= beat_idx[PTS_W-1:0];
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_en_q    <= s1_en_q;
      s2_bin_q   <= s1_bin_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: compare and update. The first beat of a frame (including a
  // restart) reseeds the maximum, so a stale frame never leaks through.
  // Strict '>' keeps the lowest index on ties.
  // ---------------------------------------------------------------------------
  always_comb begin
    max_mag_d = max_mag_q;
    max_bin_d = max_bin_q;
    if (s2_vld_q) begin
      if (s2_first_q) begin
        max_mag_d = s2_en_q ? mag : '0;
        max_bin_d = s2_en_q ? s2_bin_q : '0;
      end else if (s2_en_q && (mag > max_mag_q)) begin
        max_mag_d = mag;
        max_bin_d = s2_bin_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_mag_q <= '0;
      max_bin_q <= '0;
    end else begin
      max_mag_q <= max_mag_d;
      max_bin_q <= max_bin_d;
    end
  end

  // No beats are accepted in DRAIN/HOLD, so these are stable while valid.
  assign peak_bin   = max_bin_q;
  assign peak_mag   = max_mag_q;
  assign peak_error = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_peak_detect.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module     : tb_fft_peak_detect                                          |
// | Purpose    : Directed self-checking bench for fft_peak_detect.          |
// |              Expectations follow FFT_PEAK_DC_SKIP_EN when defined.      |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft_peak_detect;
  import fft_pkg::*;

  localparam int DW = FFT_DATA_W;
  localparam int PW = FFT_PTS_W;
  localparam int MW = FFT_MAG_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          sink_valid;
  logic          sink_ready;
  logic [1:0]    sink_error;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_real;
  logic [DW-1:0] sink_imag;
  logic [PW-1:0] fftpts_in;
  logic          peak_valid;
  logic          peak_ready;
  logic [PW-1:0] peak_bin;
  logic [MW-1:0] peak_mag;
  logic [2:0]    peak_error;

  int total = 0;
  int bad   = 0;

  int         re_a [32];
  int         im_a [32];
  logic [1:0] er_a [32];

  fft_peak_detect dut (
    .clk        (clk),
    .reset      (reset),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .sink_error (sink_error),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .sink_real  (sink_real),
    .sink_imag  (sink_imag),
    .fftpts_in  (fftpts_in),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .peak_error (peak_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 32; i++) begin
      re_a[i] = 0;
      im_a[i] = 0;
      er_a[i] = 2'b00;
    end
  endtask

  // One beat; returns 1 time unit after the edge that samples it.
  task automatic beat(input int re, input int im, input bit sop, input bit eop,
                      input logic [1:0] er);
    sink_valid = 1'b1;
    sink_real  = re[DW-1:0];
    sink_imag  = im[DW-1:0];
    sink_sop   = sop;
    sink_eop   = eop;
    sink_error = er;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    sink_error = 2'b00;
  endtask

  task automatic frame(input int n, input int cnt);
    fftpts_in = n[PW-1:0];
    for (int i = 0; i < cnt; i++) begin
      beat(re_a[i], im_a[i], (i == 0), (i == cnt - 1), er_a[i]);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (peak_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {63'd0, peak_valid}, 64'd1);
  endtask

  task automatic handshake(input string tag);
    peak_ready = 1'b1;
    @(posedge clk);
    #1;
    peak_ready = 1'b0;
    chk({tag, "_rdy"}, {63'd0, sink_ready}, 64'd1);
    chk({tag, "_vld"}, {63'd0, peak_valid}, 64'd0);
  endtask

  initial begin
    int stuck;
    logic [63:0] mneg;
    reset      = 1'b1;
    sink_valid = 1'b0;
    sink_error = 2'b00;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    sink_real  = '0;
    sink_imag  = '0;
    fftpts_in  = 14'd16;
    peak_ready = 1'b0;
    clear_frame();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_ready", {63'd0, sink_ready}, 64'd1);
    chk("rst_valid", {63'd0, peak_valid}, 64'd0);
    chk("rst_bin", {50'd0, peak_bin}, 64'd0);
    chk("rst_mag", {14'd0, peak_mag}, 64'd0);
    chk("rst_err", {61'd0, peak_error}, 64'd0);

    // Non-sop beat in IDLE is dropped
    beat(77777, 0, 1'b0, 1'b1, 2'b00);
    chk("drop_ready", {63'd0, sink_ready}, 64'd1);

    // T1: bin3 = (1000,0), rest (10,10); check exact valid latency
    clear_frame();
    for (int i = 0; i < 16; i++) begin
      re_a[i] = 10;
      im_a[i] = 10;
    end
    re_a[3] = 1000;
    im_a[3] = 0;
    frame(16, 16);
    chk("t1_v0", {63'd0, peak_valid}, 64'd0);
    chk("t1_drain_rdy", {63'd0, sink_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("t1_v1", {63'd0, peak_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("t1_v2", {63'd0, peak_valid}, 64'd1);
    chk("t1_bin", {50'd0, peak_bin}, 64'd3);
    chk("t1_mag", {14'd0, peak_mag}, 64'd1000000);
    chk("t1_err", {61'd0, peak_error}, 64'd0);
    handshake("t1_hs");

    // T2: tie at bins 2 and 5 -> lowest index
    clear_frame();
    re_a[2] = 300;
    im_a[2] = -400;
    re_a[5] = 300;
    im_a[5] = -400;
    frame(16, 16);
    wait_valid("t2_valid");
    chk("t2_bin", {50'd0, peak_bin}, 64'd2);
    chk("t2_mag", {14'd0, peak_mag}, 64'd250000);
    handshake("t2_hs");

    // T3: big value in upper half is ignored
    clear_frame();
    re_a[12] = 5000;
    im_a[12] = 5000;
    re_a[1]  = 7;
    frame(16, 16);
    wait_valid("t3_valid");
    chk("t3_bin", {50'd0, peak_bin}, 64'd1);
    chk("t3_mag", {14'd0, peak_mag}, 64'd49);

    // T4: consumer stalls 20 cycles while a new sop is offered
    sink_valid = 1'b1;
    sink_sop   = 1'b1;
    sink_real  = 25'd123;
    sink_imag  = '0;
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (sink_ready !== 1'b0 || peak_valid !== 1'b1) stuck++;
    end
    chk("t4_stall_cycles", stuck, 64'd0);
    chk("t4_bin", {50'd0, peak_bin}, 64'd1);
    chk("t4_mag", {14'd0, peak_mag}, 64'd49);
    handshake("t4_hs");
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    // New all-zero frame accepted after the handshake
    clear_frame();
    frame(16, 16);
    wait_valid("t4z_valid");
    chk("t4z_bin", {50'd0, peak_bin}, 64'd0);
    chk("t4z_mag", {14'd0, peak_mag}, 64'd0);
    chk("t4z_err", {61'd0, peak_error}, 64'd0);
    handshake("t4z_hs");

    // T5: sop + 5 beats, then restart with a full frame, max at bin 4
    fftpts_in = 14'd16;
    beat(9000, 0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) beat(8000, 0, 1'b0, 1'b0, 2'b00);
    clear_frame();
    for (int i = 0; i < 16; i++) begin
      re_a[i] = 1;
      im_a[i] = 1;
    end
    re_a[4] = 50;
    im_a[4] = 0;
    frame(16, 16);
    wait_valid("t5_valid");
    chk("t5_bin", {50'd0, peak_bin}, 64'd4);
    chk("t5_mag", {14'd0, peak_mag}, 64'd2500);
    chk("t5_err", {61'd0, peak_error}, 64'd2);
    handshake("t5_hs");

    // T5b: short frame (9 of 16) with one sink_error beat
    clear_frame();
    re_a[2] = 3;
    im_a[2] = 4;
    er_a[5] = 2'b01;
    frame(16, 9);
    wait_valid("t5b_valid");
    chk("t5b_bin", {50'd0, peak_bin}, 64'd2);
    chk("t5b_mag", {14'd0, peak_mag}, 64'd25);
    chk("t5b_err", {61'd0, peak_error}, 64'd5);
    handshake("t5b_hs");

    // Most-negative input on both parts: 2*(2^24)^2 = 2^49
    clear_frame();
    re_a[1] = -16777216;
    im_a[1] = -16777216;
    frame(4, 4);
    wait_valid("mneg_valid");
    mneg = 64'd1 << 49;
    chk("mneg_bin", {50'd0, peak_bin}, 64'd1);
    chk("mneg_mag", {14'd0, peak_mag}, mneg);
    handshake("mneg_hs");

    // T6a: reset in ACCUM
    fftpts_in = 14'd16;
    beat(0, 0, 1'b1, 1'b0, 2'b00);
    beat(100, 0, 1'b0, 1'b0, 2'b00);
    beat(0, 0, 1'b0, 1'b0, 2'b00);
    chk("t6a_pre_rdy", {63'd0, sink_ready}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t6a_valid", {63'd0, peak_valid}, 64'd0);
    chk("t6a_ready", {63'd0, sink_ready}, 64'd1);
    chk("t6a_mag", {14'd0, peak_mag}, 64'd0);

    // T6b: reset in HOLD
    clear_frame();
    re_a[2] = 5;
    frame(16, 16);
    wait_valid("t6b_hold");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t6b_valid", {63'd0, peak_valid}, 64'd0);
    chk("t6b_ready", {63'd0, sink_ready}, 64'd1);
    chk("t6b_bin", {50'd0, peak_bin}, 64'd0);

    // DC bin: bin0 = (9999,0), bin6 = (2,0)
    clear_frame();
    re_a[0] = 9999;
    re_a[6] = 2;
    frame(16, 16);
    wait_valid("dc_valid");
`ifdef FFT_PEAK_DC_SKIP_EN
    chk("dc_bin", {50'd0, peak_bin}, 64'd6);
    chk("dc_mag", {14'd0, peak_mag}, 64'd4);
`else
    chk("dc_bin", {50'd0, peak_bin}, 64'd0);
    chk("dc_mag", {14'd0, peak_mag}, 64'd99980001);
`endif
    handshake("dc_hs");

    // sop & eop together: 1-bin frame of an N=16 stream -> len_err
    fftpts_in = 14'd16;
    beat(3, 0, 1'b1, 1'b1, 2'b00);
    wait_valid("one_valid");
    chk("one_bin", {50'd0, peak_bin}, 64'd0);
`ifdef FFT_PEAK_DC_SKIP_EN
    chk("one_mag", {14'd0, peak_mag}, 64'd0);
`else
    chk("one_mag", {14'd0, peak_mag}, 64'd9);
`endif
    chk("one_err", {61'd0, peak_error}, 64'd4);
    handshake("one_hs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
